// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and uart_tx-side signal bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
    parameter int P_REQ_NUM         = 4,
    parameter int P_UART_DATA_WIDTH = 8
);
    logic [P_REQ_NUM-1:0]                   i_req;
    logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_data;
    logic [P_REQ_NUM-1:0]                   i_valid;
    logic [P_REQ_NUM-1:0]                   i_last;
    logic [P_REQ_NUM-1:0]                   o_ready;
    logic [P_REQ_NUM-1:0]                   o_gnt;
    logic [2:0]                             o_owner;
    logic                                   o_busy;
    logic                                   o_abort;
    logic [P_UART_DATA_WIDTH-1:0]           o_user_tx_data;
    logic                                   o_user_tx_valid;
    logic                                   i_user_tx_ready;

    modport slave (
        input  i_req, i_data, i_valid, i_last, i_user_tx_ready,
        output o_ready, o_gnt, o_owner, o_busy, o_abort, o_user_tx_data, o_user_tx_valid
    );

    modport master (
        output i_req, i_data, i_valid, i_last, i_user_tx_ready,
        input  o_ready, o_gnt, o_owner, o_busy, o_abort, o_user_tx_data, o_user_tx_valid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx byte channel,
// with an idle timeout that reclaims the channel from a stalled owner.
module uart_tx_arbiter #(
    parameter int P_REQ_NUM         = 4,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_TIMEOUT         = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IDX_W = (P_REQ_NUM > 1) ? $clog2(P_REQ_NUM) : 1;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

    state_t                 r_state, w_state_next;
    logic [IDX_W-1:0]       r_owner, w_owner_next;
    logic [IDX_W-1:0]       r_rr, w_rr_next;
    logic [CNT_W-1:0]       r_cnt, w_cnt_next;
    logic [P_REQ_NUM-1:0]   r_gnt, w_gnt_next;
    logic                   r_busy, w_busy_next;
    logic                   r_abort, w_abort_next;

    logic                   w_found;
    logic [IDX_W-1:0]       w_winner;
    logic [IDX_W:0]         w_cand;
    logic                   w_xfer;
    logic                   w_own_valid;
    logic                   w_own_last;
    logic [P_UART_DATA_WIDTH-1:0] w_own_data;
    logic                   w_beat;
    logic [P_REQ_NUM-1:0]   w_ready;

    // First requester at or above r_rr, wrapping past P_REQ_NUM-1.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int unsigned j = 0; j < P_REQ_NUM; j++) begin
            w_cand = {1'b0, r_rr} + (IDX_W+1)'(j);
            if (w_cand >= (IDX_W+1)'(P_REQ_NUM)) begin
                w_cand = w_cand - (IDX_W+1)'(P_REQ_NUM);
            end
            if (!w_found && bus.i_req[w_cand[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        w_own_data  = '0;
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        for (int unsigned k = 0; k < P_REQ_NUM; k++) begin
            if (r_owner == IDX_W'(k)) begin
                w_own_data  = bus.i_data[k*P_UART_DATA_WIDTH +: P_UART_DATA_WIDTH];
                w_own_valid = bus.i_valid[k];
                w_own_last  = bus.i_last[k];
            end
        end
    end

    assign w_xfer = (r_state == S_XFER);
    assign w_beat = w_xfer && w_own_valid && bus.i_user_tx_ready;

    always_comb begin
        w_ready = '0;
        for (int unsigned k = 0; k < P_REQ_NUM; k++) begin
            w_ready[k] = w_xfer && (r_owner == IDX_W'(k)) && bus.i_user_tx_ready;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_owner_next = r_owner;
        w_rr_next    = r_rr;
        w_cnt_next   = r_cnt;
        w_gnt_next   = r_gnt;
        w_busy_next  = r_busy;
        w_abort_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_next = '0;
                if (w_found) begin
                    w_state_next         = S_XFER;
                    w_owner_next         = w_winner;
                    w_gnt_next           = '0;
                    w_gnt_next[w_winner] = 1'b1;
                    w_busy_next          = 1'b1;
                end
            end
            S_XFER: begin
                // Backpressure (valid high, ready low) leaves the counter untouched.
                if (w_beat) begin
                    w_cnt_next = '0;
                    if (w_own_last) begin
                        w_state_next = S_GAP;
                        w_gnt_next   = '0;
                        w_busy_next  = 1'b0;
                    end
                end else if (!w_own_valid) begin
                    if (r_cnt == CNT_W'(P_TIMEOUT - 1)) begin
                        w_state_next = S_GAP;
                        w_gnt_next   = '0;
                        w_busy_next  = 1'b0;
                        w_abort_next = 1'b1;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
            end
            S_GAP: begin
                w_rr_next    = (r_owner == IDX_W'(P_REQ_NUM - 1)) ? '0 : r_owner + IDX_W'(1);
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_rr    <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_owner <= w_owner_next;
            r_rr    <= w_rr_next;
            r_cnt   <= w_cnt_next;
            r_gnt   <= w_gnt_next;
            r_busy  <= w_busy_next;
            r_abort <= w_abort_next;
        end
    end

    assign bus.o_ready         = w_ready;
    assign bus.o_gnt           = r_gnt;
    assign bus.o_owner         = 3'(r_owner);
    assign bus.o_busy          = r_busy;
    assign bus.o_abort         = r_abort;
    assign bus.o_user_tx_valid = w_xfer && w_own_valid;
    assign bus.o_user_tx_data  = w_xfer ? w_own_data : '0;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized bench for uart_tx_arbiter, checked each cycle against a packet-level model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    uart_tx_arbiter_if #(.P_REQ_NUM(N), .P_UART_DATA_WIDTH(W)) bus ();

    uart_tx_arbiter #(.P_REQ_NUM(N), .P_UART_DATA_WIDTH(W), .P_TIMEOUT(TO)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Packet sources: bit 8 of each entry marks the last byte.
    logic [8:0]   src_q [N][$];
    logic [N-1:0] req_force   = '0;
    logic [N-1:0] stall       = '0;
    int           stall_cnt [N];
    logic         rand_mode   = 1'b0;
    logic         ready_force = 1'b1;
    logic [N-1:0] acc         = '0;
    int           cyc         = 0;

    always @(posedge i_clk) cyc <= cyc + 1;
    always @(negedge i_clk) acc = bus.i_valid & bus.o_ready;

    always @(posedge i_clk) begin
        int   len;
        logic v;
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            if (rand_mode) begin
                if (src_q[k].size() == 0 && $urandom_range(0, 5) == 0) begin
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++) src_q[k].push_back({(b == len - 1), 8'($urandom)});
                end
                if (stall_cnt[k] > 0) stall_cnt[k]--;
                else if ($urandom_range(0, 149) == 0) stall_cnt[k] = $urandom_range(8, 30);
                stall[k] = (stall_cnt[k] > 0);
            end
            bus.i_req[k] = req_force[k] || (src_q[k].size() > 0);
            v = (src_q[k].size() > 0) && !stall[k] && (!rand_mode || $urandom_range(0, 9) < 8);
            bus.i_valid[k] = v;
            if (src_q[k].size() > 0 && (v || !rand_mode)) begin
                bus.i_data[k*W +: W] = src_q[k][0][7:0];
                bus.i_last[k]        = src_q[k][0][8];
            end else begin
                bus.i_data[k*W +: W] = rand_mode ? 8'($urandom) : 8'h00;
                bus.i_last[k]        = rand_mode ? 1'($urandom) : 1'b0;
            end
        end
        bus.i_user_tx_ready = rand_mode ? ($urandom_range(0, 9) < 7) : ready_force;
    end

    // Reference model: who holds the channel, cooldown after release, idle run length.
    int m_owner = 0, m_ptr = 0, m_cool = 0, m_idle = 0;
    bit m_hold = 0, m_abort = 0;

    always @(negedge i_clk) begin
        logic [N-1:0] e_gnt, e_rdy;
        logic [W-1:0] e_dat;
        logic         e_val;
        if (i_rst) begin
            m_hold = 0; m_owner = 0; m_ptr = 0; m_cool = 0; m_idle = 0; m_abort = 0;
        end
        e_gnt = '0; e_rdy = '0; e_dat = '0; e_val = 1'b0;
        if (m_hold) begin
            e_gnt[m_owner] = 1'b1;
            e_val          = bus.i_valid[m_owner];
            e_dat          = bus.i_data[m_owner*W +: W];
            e_rdy[m_owner] = bus.i_user_tx_ready;
        end
        chk("gnt",      bus.o_gnt,           e_gnt);
        chk("owner",    bus.o_owner,         m_owner);
        chk("busy",     bus.o_busy,          m_hold);
        chk("abort",    bus.o_abort,         m_abort);
        chk("tx_valid", bus.o_user_tx_valid, e_val);
        chk("tx_data",  bus.o_user_tx_data,  e_dat);
        chk("ready",    bus.o_ready,         e_rdy);
        if (!i_rst) begin
            m_abort = 0;
            if (m_hold) begin
                if (bus.i_valid[m_owner] && bus.i_user_tx_ready) begin
                    m_idle = 0;
                    if (bus.i_last[m_owner]) begin
                        m_hold = 0; m_cool = 1; m_ptr = (m_owner + 1) % N;
                    end
                end else if (!bus.i_valid[m_owner]) begin
                    m_idle++;
                    if (m_idle == TO) begin
                        m_hold = 0; m_cool = 1; m_ptr = (m_owner + 1) % N; m_abort = 1;
                    end
                end
            end else if (m_cool > 0) begin
                m_cool--;
            end else if (bus.i_req != '0) begin
                for (int j = 0; j < N; j++) begin
                    if (!m_hold && bus.i_req[(m_ptr + j) % N]) begin
                        m_owner = (m_ptr + j) % N;
                        m_hold  = 1;
                    end
                end
                m_idle = 0;
            end
        end
    end

    // Event logs for the literal expectations.
    int g_cyc[$], g_own[$], g_val[$], b_cyc[$], b_dat[$], b_own[$], a_cyc[$], f_cyc[$];
    int r_rise [N];
    logic [N-1:0] prev_gnt = '0, prev_req = '0;
    logic         prev_busy = 1'b0;

    always @(negedge i_clk) begin
        if (bus.o_gnt != '0 && prev_gnt == '0) begin
            g_cyc.push_back(cyc); g_own.push_back(int'(bus.o_owner)); g_val.push_back(int'(bus.o_gnt));
        end
        if (bus.o_user_tx_valid && bus.i_user_tx_ready) begin
            b_cyc.push_back(cyc); b_dat.push_back(int'(bus.o_user_tx_data)); b_own.push_back(int'(bus.o_owner));
        end
        if (bus.o_abort) a_cyc.push_back(cyc);
        if (!bus.o_busy && prev_busy) f_cyc.push_back(cyc);
        for (int k = 0; k < N; k++) if (bus.i_req[k] && !prev_req[k]) r_rise[k] = cyc;
        prev_gnt  = bus.o_gnt;
        prev_busy = bus.o_busy;
        prev_req  = bus.i_req;
    end

    task automatic clear_logs();
        g_cyc.delete(); g_own.delete(); g_val.delete();
        b_cyc.delete(); b_dat.delete(); b_own.delete();
        a_cyc.delete(); f_cyc.delete();
    endtask

    task automatic clear_sources();
        for (int k = 0; k < N; k++) begin
            src_q[k].delete();
            stall_cnt[k] = 0;
        end
        req_force   = '0;
        stall       = '0;
        rand_mode   = 1'b0;
        ready_force = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        clear_sources();
        repeat (2) @(posedge i_clk);
        #2 i_rst = 1'b0;
        clear_logs();
    endtask

    // which: 0 grants, 1 beats, 2 busy falls
    task automatic wait_for(input int which, input int n, input int budget, input string name);
        int i = 0;
        int sz;
        sz = (which == 0) ? g_cyc.size() : (which == 1) ? b_cyc.size() : f_cyc.size();
        while (sz < n && i < budget) begin
            @(posedge i_clk);
            i++;
            sz = (which == 0) ? g_cyc.size() : (which == 1) ? b_cyc.size() : f_cyc.size();
        end
        chk(name, (sz >= n), 1'b1);
    endtask

    int t1_exp [3] = '{'h11, 'h22, 'h33};
    int t2_ord [5] = '{0, 1, 2, 3, 0};
    int t5_ord [3] = '{3, 0, 3};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            stall_cnt[k] = 0;
            r_rise[k]    = 0;
        end
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #3;
        chk("rst_gnt",   bus.o_gnt,           0);
        chk("rst_owner", bus.o_owner,         0);
        chk("rst_busy",  bus.o_busy,          0);
        chk("rst_abort", bus.o_abort,         0);
        chk("rst_valid", bus.o_user_tx_valid, 0);
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        clear_logs();

        // Single requester, three-byte packet.
        @(posedge i_clk);
        src_q[1].push_back(9'h011); src_q[1].push_back(9'h022); src_q[1].push_back(9'h133);
        wait_for(2, 1, 40, "t1_wait");
        repeat (3) @(posedge i_clk);
        chk("t1_grants", g_cyc.size(), 1);
        chk("t1_beats",  b_cyc.size(), 3);
        if (g_cyc.size() >= 1 && b_cyc.size() >= 3 && f_cyc.size() >= 1) begin
            chk("t1_gnt_lat", g_cyc[0] - r_rise[1], 1);
            chk("t1_gnt_val", g_val[0], 'b0010);
            for (int i = 0; i < 3; i++) begin
                chk("t1_byte",     b_dat[i], t1_exp[i]);
                chk("t1_beat_cyc", b_cyc[i] - g_cyc[0], i);
            end
            chk("t1_busy_drop", f_cyc[0] - b_cyc[2], 1);
        end

        // All four requesting one-byte packets.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) src_q[k].push_back(9'h100 | 9'(8'hA0 + k));
        wait_for(1, 8, 200, "t2_wait");
        repeat (3) @(posedge i_clk);
        if (g_own.size() >= 5 && b_dat.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("t2_order", g_own[i], t2_ord[i]);
                chk("t2_byte",  b_dat[i], 'hA0 + t2_ord[i]);
            end
            for (int i = 0; i < 4; i++) chk("t2_spacing", b_cyc[i+1] - b_cyc[i], 3);
        end

        // Long backpressure never times out.
        do_reset();
        ready_force = 1'b0;
        src_q[2].push_back(9'h15A);
        repeat (2000) @(posedge i_clk);
        chk("t3_no_beat",  b_cyc.size(), 0);
        chk("t3_no_abort", a_cyc.size(), 0);
        chk("t3_grants",   g_own.size(), 1);
        ready_force = 1'b1;
        repeat (6) @(posedge i_clk);
        chk("t3_one_beat", b_cyc.size(), 1);
        if (b_cyc.size() >= 1) begin
            chk("t3_byte",  b_dat[0], 'h5A);
            chk("t3_owner", b_own[0], 2);
        end
        chk("t3_no_abort_end", a_cyc.size(), 0);

        // Silent owner 0 is released by timeout.
        do_reset();
        req_force[0] = 1'b1;
        src_q[1].push_back(9'h177);
        wait_for(0, 1, 20, "t4_wait_g0");
        req_force[0] = 1'b0;
        wait_for(0, 2, 60, "t4_wait_g1");
        repeat (4) @(posedge i_clk);
        chk("t4_aborts", a_cyc.size(), 1);
        if (g_cyc.size() >= 2 && a_cyc.size() >= 1) begin
            chk("t4_first",      g_own[0], 0);
            chk("t4_abort_time", a_cyc[0] - g_cyc[0], TO);
            chk("t4_next",       g_own[1], 1);
            chk("t4_next_time",  g_cyc[1] - a_cyc[0], 2);
        end

        // Wrap from owner 3 back to 0, then 3 again.
        do_reset();
        src_q[3].push_back(9'h031); src_q[3].push_back(9'h132); src_q[3].push_back(9'h133);
        wait_for(0, 1, 20, "t5_wait_g");
        src_q[0].push_back(9'h101);
        wait_for(1, 4, 60, "t5_wait_b");
        repeat (4) @(posedge i_clk);
        chk("t5_grants", g_own.size(), 3);
        if (g_own.size() >= 3)
            for (int i = 0; i < 3; i++) chk("t5_order", g_own[i], t5_ord[i]);

        // Asynchronous reset mid-packet.
        do_reset();
        src_q[1].push_back(9'h010); src_q[1].push_back(9'h011);
        src_q[1].push_back(9'h012); src_q[1].push_back(9'h113);
        wait_for(1, 1, 20, "t6_wait_b");
        #2 i_rst = 1'b1;
        #1;
        chk("t6_gnt",   bus.o_gnt,           0);
        chk("t6_busy",  bus.o_busy,          0);
        chk("t6_valid", bus.o_user_tx_valid, 0);
        chk("t6_data",  bus.o_user_tx_data,  0);
        chk("t6_ready", bus.o_ready,         0);
        chk("t6_owner", bus.o_owner,         0);
        clear_sources();
        @(posedge i_clk);
        #2 i_rst = 1'b0;
        clear_logs();
        src_q[0].push_back(9'h140);
        src_q[1].push_back(9'h141);
        wait_for(0, 2, 40, "t6_wait_g");
        repeat (4) @(posedge i_clk);
        if (g_own.size() >= 2) begin
            chk("t6_first",  g_own[0], 0);
            chk("t6_second", g_own[1], 1);
        end

        // Randomized traffic with valid gaps, backpressure and stalls.
        do_reset();
        rand_mode = 1'b1;
        repeat (4000) @(posedge i_clk);
        clear_sources();
        repeat (60) @(posedge i_clk);
        chk("rnd_beats", (b_cyc.size() > 100), 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
